ir_pulse_meter: RTL and testbench

Front end of the IR receive path. Synchronises and deglitches the raw IR demodulator pin, then measures each constant-level segment in prescaled ticks. Each segment is pushed as a (level, length) event into a small FIFO. The NEC frame decoder downstream pops the FIFO over a valid/ready handshake and classifies leader, bit and repeat pulses from these events. It never sees the raw pin.

---
 rtl/ir_pulse_meter.sv | 181 ++++++++++++++++++
 tb/tb_ir_pulse_meter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_pulse_meter.sv
// ir_pulse_meter: synchronises and deglitches the IR demodulator pin, times
// each constant-level segment in prescaled ticks and queues (level, length)
// events for the frame decoder over a valid/ready handshake.
module ir_pulse_meter #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEGLITCH_CYC = 4,
    parameter int DUR_W        = 12,
    parameter int DEPTH        = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             ir_i,
    input  logic             invert_i,
    input  logic             enable_i,
    input  logic [15:0]      tick_period_i,
    input  logic             clr_i,
    output logic             pulse_valid_o,
    input  logic             pulse_ready_i,
    output logic             pulse_level_o,
    output logic [DUR_W-1:0] pulse_len_o,
    output logic             pulse_ovf_o,
    output logic             overrun_o,
    output logic             idle_o
);

    localparam int DG_W = $clog2(DEGLITCH_CYC + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int EW   = DUR_W + 2;
    localparam logic [DUR_W-1:0] LEN_MAX = '1;

    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   f_q, f_d;
    logic [DG_W-1:0]        dg_q, dg_d;
    logic                   edge_acc;

    logic [15:0]            p_last;
    logic                   tick;
    logic [15:0]            pre_q, pre_d;

    state_t                 state_q, state_d;
    logic [DUR_W-1:0]       len_q, len_d;
    logic                   push;
    logic [EW-1:0]          push_entry;

    logic [EW-1:0]          mem_q [DEPTH];
    logic [EW-1:0]          mem_d [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   full;
    logic                   pop;
    logic                   do_push;

    // Synchroniser shift and deglitch filter producing the accepted-edge strobe
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], ir_i};
        s        = sync_q[SYNC_STAGES-1] ^ invert_i;
        f_d      = f_q;
        dg_d     = '0;
        edge_acc = 1'b0;
        if (s != f_q) begin
            if (dg_q == DG_W'(DEGLITCH_CYC - 1)) begin
                f_d      = ~f_q;
                edge_acc = 1'b1;
            end else begin
                dg_d = dg_q + DG_W'(1);
            end
        end
    end

    // Tick prescaler, realigned to every accepted edge
    always_comb begin
        p_last = (tick_period_i == 16'd0) ? 16'd0 : tick_period_i - 16'd1;
        // >= keeps the count bounded if the period shrinks mid-count
        tick   = (pre_q >= p_last);
        pre_d  = (edge_acc || tick) ? 16'd0 : pre_q + 16'd1;
    end

    // Segment timer: measures between accepted edges, emits timeout events
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            ST_IDLE: begin
                len_d = '0;
                if (edge_acc) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (edge_acc) begin
                    push       = 1'b1;
                    push_entry = {f_q, 1'b0, len_q};
                    len_d      = '0;
                end else if (tick) begin
                    if (len_q == LEN_MAX - DUR_W'(1)) begin
                        push       = 1'b1;
                        push_entry = {f_q, 1'b1, LEN_MAX};
                        len_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        len_d = len_q + DUR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable_i) begin
            state_d = ST_IDLE;
            len_d   = '0;
            push    = 1'b0;
        end
    end

    // Event FIFO: same-cycle pop frees a slot for a push; clr wins over all
    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        pop       = (cnt_q != '0) && pulse_ready_i;
        do_push   = push && (!full || pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (clr_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            if (push && full && !pop) overrun_d = 1'b1;
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !pop) cnt_d = cnt_q + CW'(1);
            else if (!do_push && pop) cnt_d = cnt_q - CW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q    <= '0;
            f_q       <= 1'b0;
            dg_q      <= '0;
            pre_q     <= '0;
            state_q   <= ST_IDLE;
            len_q     <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            f_q       <= f_d;
            dg_q      <= dg_d;
            pre_q     <= pre_d;
            state_q   <= state_d;
            len_q     <= len_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign pulse_valid_o = (cnt_q != '0);
    assign {pulse_level_o, pulse_ovf_o, pulse_len_o} = mem_q[rd_ptr_q];
    assign overrun_o     = overrun_q;
    assign idle_o        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ir_pulse_meter.sv
// Directed bench for ir_pulse_meter: a default instance (DUR_W=12) for the
// segment, glitch, FIFO and inversion cases and a DUR_W=4 instance for timeout.
module tb_ir_pulse_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir, invert, enable, clr, ready;
    logic [15:0] tp;
    logic        valid, level, ovf, overrun, idle;
    logic [11:0] len;

    logic        ir1, ready1;
    logic        valid1, level1, ovf1, overrun1, idle1;
    logic [3:0]  len1;
    logic        invert1 = 1'b0;
    logic        enable1 = 1'b1;
    logic        clr1    = 1'b0;
    logic [15:0] tp1     = 16'd0;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    ir_pulse_meter #(.SYNC_STAGES(2), .DEGLITCH_CYC(4), .DUR_W(12), .DEPTH(4)) u0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .ir_i(ir), .invert_i(invert),
        .enable_i(enable), .tick_period_i(tp), .clr_i(clr),
        .pulse_valid_o(valid), .pulse_ready_i(ready), .pulse_level_o(level),
        .pulse_len_o(len), .pulse_ovf_o(ovf), .overrun_o(overrun), .idle_o(idle)
    );

    ir_pulse_meter #(.SYNC_STAGES(2), .DEGLITCH_CYC(4), .DUR_W(4), .DEPTH(4)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .ir_i(ir1), .invert_i(invert1),
        .enable_i(enable1), .tick_period_i(tp1), .clr_i(clr1),
        .pulse_valid_o(valid1), .pulse_ready_i(ready1), .pulse_level_o(level1),
        .pulse_len_o(len1), .pulse_ovf_o(ovf1), .overrun_o(overrun1), .idle_o(idle1)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop0();
        ready = 1'b1;
        step(1);
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ir = 1'b0; invert = 1'b0; enable = 1'b1; clr = 1'b0;
        ready = 1'b0; tp = 16'd10; ir1 = 1'b0; ready1 = 1'b0;

        // Reset with the pin toggling
        for (int i = 0; i < 3; i++) begin
            ir = ~ir;
            step(1);
        end
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_len", len, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_idle", idle, 1);
        chk("rst_idle1", idle1, 1);
        rst = 1'b0; ir = 1'b0;
        step(10);

        // Clean segments: 900 clocks high, 300 low, P=10
        ir = 1'b1;
        step(20);
        chk("first_edge_noevent", valid, 0);
        chk("first_edge_measure", idle, 0);
        step(880);
        ir = 1'b0;
        step(5);
        chk("latency_5", valid, 0);
        step(1);
        chk("latency_6", valid, 1);
        chk("seg1_level", level, 1);
        chk("seg1_len_89_90", (len == 12'd89 || len == 12'd90) ? 1 : 0, 1);
        chk("seg1_ovf", ovf, 0);
        step(3);
        chk("hold_valid", valid, 1);
        chk("hold_level", level, 1);
        pop0();
        chk("pop_empty", valid, 0);
        step(290);
        ir = 1'b1;
        step(6);
        chk("seg2_valid", valid, 1);
        chk("seg2_level", level, 0);
        chk("seg2_len_29_30", (len == 12'd29 || len == 12'd30) ? 1 : 0, 1);
        chk("seg2_ovf", ovf, 0);
        pop0();

        // Glitches: two 3-clock pulses ignored, then a 4-clock pulse accepted
        step(20);
        ir = 1'b0; step(3); ir = 1'b1;
        step(20);
        ir = 1'b0; step(3); ir = 1'b1;
        step(50);
        chk("glitch_noevent", valid, 0);
        chk("glitch_measure", idle, 0);
        step(102);
        ir = 1'b0; step(4); ir = 1'b1;
        step(2);
        chk("g1_valid", valid, 1);
        chk("g1_level", level, 1);
        chk("g1_len", len, 20);
        chk("g1_ovf", ovf, 0);
        pop0();
        step(3);
        chk("g2_valid", valid, 1);
        chk("g2_level", level, 0);
        chk("g2_len", len, 0);
        pop0();

        // Overflow: six 25-clock segments with no consumer
        step(18);
        for (int i = 0; i < 6; i++) begin
            ir = ~ir;
            step(25);
        end
        chk("ovr_set", overrun, 1);
        chk("ovr_valid", valid, 1);
        for (int i = 0; i < 3; i++) begin
            chk("ovr_order_level", level, (i % 2 == 0) ? 1 : 0);
            chk("ovr_order_len", len, 2);
            chk("ovr_order_ovf", ovf, 0);
            pop0();
        end
        chk("ovr_last_level", level, 0);
        chk("ovr_sticky", overrun, 1);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("clr_empty", valid, 0);
        chk("clr_overrun", overrun, 0);

        // Fill to full, then push and pop on the same edge
        for (int i = 0; i < 4; i++) begin
            ir = ~ir;
            step(25);
        end
        chk("full_valid", valid, 1);
        chk("full_no_ovr", overrun, 0);
        ir = ~ir;
        step(5);
        ready = 1'b1; step(1); ready = 1'b0;
        chk("pushpop_no_ovr", overrun, 0);
        chk("pushpop_valid", valid, 1);
        chk("pushpop_head", level, 0);
        chk("pushpop_len", len, 2);
        clr = 1'b1; step(1); clr = 1'b0;

        // Active-low pin carrying a NEC leader
        enable = 1'b0;
        step(2);
        chk("dis_idle", idle, 1);
        invert = 1'b1; ir = 1'b1;
        step(20);
        clr = 1'b1; step(1); clr = 1'b0;
        enable = 1'b1;
        step(2);
        chk("inv_idle", idle, 1);
        chk("inv_empty", valid, 0);
        ir = 1'b0; step(1600);
        ir = 1'b1; step(800);
        ir = 1'b0; step(6);
        chk("nec1_valid", valid, 1);
        chk("nec1_level", level, 1);
        chk("nec1_len_159_160", (len == 12'd159 || len == 12'd160) ? 1 : 0, 1);
        chk("nec1_ovf", ovf, 0);
        pop0();
        chk("nec2_level", level, 0);
        chk("nec2_len_79_80", (len == 12'd79 || len == 12'd80) ? 1 : 0, 1);
        pop0();
        chk("nec_empty", valid, 0);

        // Enable dropped mid-segment
        step(100);
        chk("en_measure", idle, 0);
        enable = 1'b0;
        step(2);
        chk("en_drop_idle", idle, 1);
        ir = 1'b1;
        step(20);
        chk("en_drop_noevent", valid, 0);
        chk("en_drop_noovr", overrun, 0);

        // Timeout on the DUR_W=4 instance, period 0 acting as 1
        ir1 = 1'b1;
        step(100);
        chk("to_valid", valid1, 1);
        chk("to_level", level1, 1);
        chk("to_len", len1, 15);
        chk("to_ovf", ovf1, 1);
        chk("to_idle", idle1, 1);
        ready1 = 1'b1; step(1); ready1 = 1'b0;
        chk("to_single", valid1, 0);
        ir1 = 1'b0;
        step(10);
        chk("to_next_noevent", valid1, 0);
        chk("to_next_measure", idle1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
